// File: rtl/fac_bus_master_pkg.sv
// Shared types for the factorial bus master: FSM state encoding,
// core register offsets, address limits and the per-state bus decode.
package fac_bus_master_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_W_CLR1,
    S_W_CLR0,
    S_W_OPR,
    S_W_IEN,
    S_W_GO,
    S_WAIT_INT,
    S_R_H,
    S_R_L,
    S_W_ML,
    S_W_MH,
    S_W_FIN,
    S_W_FIN0,
    S_DONE
  } state_e;

  localparam logic [15:0] OFF_OPSTART = 16'h0000;
  localparam logic [15:0] OFF_OPCLEAR = 16'h0008;
  localparam logic [15:0] OFF_OPDONE  = 16'h0010;
  localparam logic [15:0] OFF_INTREN  = 16'h0018;
  localparam logic [15:0] OFF_OPERAND = 16'h0020;
  localparam logic [15:0] OFF_RES_H   = 16'h0028;
  localparam logic [15:0] OFF_RES_L   = 16'h0030;

  localparam logic [15:0] FAC_BASE_DEF = 16'h7000;
  localparam logic [15:0] MEM_TOP      = 16'h07FF;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [63:0] dout;
  } bus_t;

  // Bus pins presented while sitting in state s.
  // Reads always drive dout=0.
  function automatic bus_t bus_for(
    input state_e      s,
    input logic [15:0] base,
    input logic [63:0] n,
    input logic [15:0] dst,
    input logic [63:0] rh,
    input logic [63:0] rl
  );
    bus_t b;
    b     = '0;
    b.req = !(s inside {S_IDLE, S_DONE});
    case (s)
      S_W_CLR1, S_W_FIN: begin
        b.wr   = 1'b1;
        b.addr = base + OFF_OPCLEAR;
        b.dout = 64'd1;
      end
      S_W_CLR0, S_W_FIN0: begin
        b.wr   = 1'b1;
        b.addr = base + OFF_OPCLEAR;
      end
      S_W_OPR: begin
        b.wr   = 1'b1;
        b.addr = base + OFF_OPERAND;
        b.dout = n;
      end
      S_W_IEN: begin
        b.wr   = 1'b1;
        b.addr = base + OFF_INTREN;
        b.dout = 64'd1;
      end
      S_W_GO: begin
        b.wr   = 1'b1;
        b.addr = base + OFF_OPSTART;
        b.dout = 64'd1;
      end
      S_WAIT_INT: b.addr = base + OFF_OPDONE;
      S_R_H:      b.addr = base + OFF_RES_H;
      S_R_L:      b.addr = base + OFF_RES_L;
      S_W_ML: begin
        b.wr   = 1'b1;
        b.addr = dst;
        b.dout = rl;
      end
      S_W_MH: begin
        b.wr   = 1'b1;
        b.addr = dst + 16'd1;
        b.dout = rh;
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fac_bus_master_timer.sv
// fbm_timer: loadable up-counter with enable, saturating at LIMIT.
// Ports: clk, reset_n, load_i (clear), en_i (count), expire_o.
module fbm_timer #(
  parameter int unsigned LIMIT = 4096,
  localparam int unsigned W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && cnt_q != W'(LIMIT)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // High in the cycle whose enabled count reaches LIMIT.
  assign expire_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/fac_bus_master.sv
// Bus master that runs one factorial job on the core at FAC_BASE and
// stores the 128-bit result to memory at dst_addr / dst_addr+1.
// Inputs: clk, reset_n, start, n_in, dst_addr, m_grant, m_din, interrupt.
// Outputs: m_req/m_wr/m_addr/m_dout (bus), busy, done, error,
// result_h/result_l.
module fac_bus_master
  import fac_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 4096,
  parameter logic [15:0] FAC_BASE = FAC_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [63:0] n_in,
  input  logic [15:0] dst_addr,
  input  logic        m_grant,
  input  logic [63:0] m_din,
  input  logic        interrupt,
  output logic        m_req,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] result_h,
  output logic [63:0] result_l
);

  state_e      state_q, state_d;
  logic        rd_ph_q, rd_ph_d;
  logic [63:0] n_q, n_d;
  logic [15:0] dst_q, dst_d;
  logic [63:0] rh_q, rh_d;
  logic [63:0] rl_q, rl_d;
  logic        err_q, err_d;
  logic        busy_q, done_q;
  bus_t        bus_q;
  logic        tmr_load, tmr_en, tmr_exp;

  fbm_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expire_o (tmr_exp)
  );

  // Every non-idle state is a bus access, so a missing grant
  // simply holds the state and everything derived from it.
  always_comb begin
    state_d  = state_q;
    rd_ph_d  = rd_ph_q;
    n_d      = n_q;
    dst_d    = dst_q;
    rh_d     = rh_q;
    rl_d     = rl_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (dst_addr > (MEM_TOP - 16'd1)) begin
            err_d = 1'b1;
          end else begin
            state_d = S_REQ;
            n_d     = n_in;
            dst_d   = dst_addr;
          end
        end
      end
      S_REQ:    if (m_grant) state_d = S_W_CLR1;
      S_W_CLR1: if (m_grant) state_d = S_W_CLR0;
      S_W_CLR0: if (m_grant) state_d = S_W_OPR;
      S_W_OPR:  if (m_grant) state_d = S_W_IEN;
      S_W_IEN:  if (m_grant) state_d = S_W_GO;
      S_W_GO: begin
        if (m_grant) begin
          state_d  = S_WAIT_INT;
          tmr_load = 1'b1;
        end
      end
      S_WAIT_INT: begin
        if (m_grant) begin
          if (interrupt) begin
            state_d = S_R_H;
          end else begin
            tmr_en = 1'b1;
            if (tmr_exp) begin
              err_d   = 1'b1;
              state_d = S_W_FIN;
            end
          end
        end
      end
      // Reads take two granted cycles; data is taken on the second.
      S_R_H: begin
        if (m_grant) begin
          rd_ph_d = !rd_ph_q;
          if (rd_ph_q) begin
            rh_d    = m_din;
            state_d = S_R_L;
          end
        end
      end
      S_R_L: begin
        if (m_grant) begin
          rd_ph_d = !rd_ph_q;
          if (rd_ph_q) begin
            rl_d    = m_din;
            state_d = S_W_ML;
          end
        end
      end
      S_W_ML:  if (m_grant) state_d = S_W_MH;
      S_W_MH:  if (m_grant) state_d = S_W_FIN;
      S_W_FIN: if (m_grant) state_d = S_W_FIN0;
      // A timed-out job reaches here with error set and skips DONE.
      S_W_FIN0: if (m_grant) state_d = err_q ? S_IDLE : S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rd_ph_q <= 1'b0;
      n_q     <= '0;
      dst_q   <= '0;
      rh_q    <= '0;
      rl_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_ph_q <= rd_ph_d;
      n_q     <= n_d;
      dst_q   <= dst_d;
      rh_q    <= rh_d;
      rl_q    <= rl_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      bus_q   <= bus_for(state_d, FAC_BASE, n_d, dst_d, rh_d, rl_d);
    end
  end

  assign m_req    = bus_q.req;
  assign m_wr     = bus_q.wr;
  assign m_addr   = bus_q.addr;
  assign m_dout   = bus_q.dout;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = err_q;
  assign result_h = rh_q;
  assign result_l = rl_q;

endmodule

// File: doc/fac_bus_master.md
FAC_BUS_MASTER -- requirements
Module: fac_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 4096, maximum cycles to wait for the factorial interrupt.
REQ-002 Parameter FAC_BASE, default 16'h7000, base address of the factorial core register block.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse; launches one job when idle.
REQ-006 n_in  input  64  factorial operand, sampled on accepted start.
REQ-007 dst_addr  input  16  memory word address for result_l, sampled on accepted start; result_h goes to dst_addr+1.
REQ-008 m_grant  input  1  bus grant from arbiter.
REQ-009 m_din  input  64  bus read data.
REQ-010 interrupt  input  1  factorial-core completion interrupt.
REQ-011 m_req  output  1  bus request.
REQ-012 m_wr  output  1  1 = write, 0 = read.
REQ-013 m_addr  output  16  bus address.
REQ-014 m_dout  output  64  bus write data.
REQ-015 busy  output  1  high from accepted start until done/error.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 error  output  1  sticky; set on timeout or bad dst_addr; cleared by next accepted start.
REQ-018 result_h, result_l  output  64 each  captured factorial result.

Function
REQ-019 Register offsets from FAC_BASE: opstart 0x00, opclear 0x08, opdone 0x10, intrEn 0x18, operand 0x20, result_h 0x28, result_l 0x30.
REQ-020 start is accepted only in IDLE; ignored otherwise.
REQ-021 If dst_addr > 16'h07FE on start: no bus activity, error=1, return to IDLE in one cycle.
REQ-022 States, in order: IDLE, REQ, W_CLR1 (opclear<=1), W_CLR0 (opclear<=0), W_OPR (operand<=n), W_IEN (intrEn<=1), W_GO (opstart<=1), WAIT_INT, R_H, R_L, W_ML (mem[dst]<=result_l), W_MH (mem[dst+1]<=result_h), W_FIN (opclear<=1), W_FIN0 (opclear<=0), DONE.
REQ-023 m_req held high from REQ through W_FIN0, including WAIT_INT; low in IDLE and DONE.
REQ-024 A write completes on a rising edge with m_req & m_grant & m_wr; state advances on that edge.
REQ-025 A read holds m_addr with m_wr=0 for two granted cycles; m_din sampled on the second edge.
REQ-026 When m_grant is low, the current access stalls with m_addr/m_wr/m_dout held; no state advance, timeout counter frozen.
REQ-027 In WAIT_INT: m_wr=0, m_addr=FAC_BASE+0x10; advance on interrupt=1, cycle counter resets on entry.
REQ-028 If counter reaches TIMEOUT in WAIT_INT: error=1, jump to W_FIN (clear core), then IDLE without done.
REQ-029 DONE lasts one cycle: done=1, busy=0 next cycle, return to IDLE; start may be accepted the cycle after DONE.
REQ-030 result_h/result_l update only in R_H/R_L; they hold across later jobs until overwritten.
REQ-031 m_dout is 0 whenever m_wr=0.

Reset
REQ-032 On reset_n=0 immediately: state IDLE, m_req=0, m_wr=0, m_addr=0, m_dout=0, busy=0, done=0, error=0, result_h=0, result_l=0, counter=0.
REQ-033 Reset mid-job abandons the job; no further bus cycles are issued; the core is not cleared.

Structure
REQ-034 Shared package holds the state encoding, register offsets, FAC_BASE and MEM_TOP (16'h07FF).
REQ-035 One sub-module, fbm_timer: loadable cycle counter with enable and expiry flag.

Verification
REQ-036 Start n=8, dst=0x0010, grant tied 1 -> writes 1,0,8,1,1 to 0x7008,0x7008,0x7020,0x7018,0x7000; result_l=0x9D80, result_h=0; mem[0x10]=0x9D80, mem[0x11]=0; one done pulse.
REQ-037 Start n=0, dst=0x0000 -> result_l=1, result_h=0, done pulse, error=0.
REQ-038 Grant dropped 5 cycles during W_OPR and R_L -> bus outputs frozen, same final results as REQ-036.
REQ-039 Interrupt forced low, TIMEOUT=16 -> error=1 after 16 WAIT_INT cycles, opclear 1 then 0 written, no done, busy falls.
REQ-040 dst=0x07FF -> error=1, m_req never asserted; reset_n pulsed in WAIT_INT -> all outputs 0 asynchronously.
